// File: rtl/frame_sync_deframer.sv
// -----------------------------------------------------------------------------
// frame_sync_deframer
//
// Receive-side deframer placed after the DQPSK demodulator. Hunts the serial
// bit stream for a periodic sync word (tolerating up to MAX_ERR bit errors and
// a 180-degree polarity inversion), verifies it over LOCK_CNT consecutive
// periods, then emits byte-aligned payload with frame markers. Lock is held
// across isolated sync misses (flywheel) until LOSS_CNT consecutive misses.
//
// Optional feature macro: FRAME_DESCRAMBLE_EN
//   defined   -> payload passes through an additive x^15+x^14+1 descrambler,
//                seeded with 15'h7FFF at every sync check and on entry to VERIFY
//   undefined -> payload only gets polarity correction, no LFSR is built
//
// Ports
//   clk_bitsync  in   recovered bit clock, rising edge
//   rstn         in   asynchronous active-low reset
//   bit_en       in   qualifies bit_in, one bit per high cycle
//   bit_in       in   demodulated serial bit
//   byte_out     out  payload byte, first received bit in bit 7
//   byte_valid   out  one-cycle strobe for byte_out
//   frame_start  out  high with byte_valid of payload byte 0
//   frame_end    out  high with byte_valid of the last payload byte
//   locked       out  high while in LOCK
//   inverted     out  polarity flag latched at acquisition
// -----------------------------------------------------------------------------
module frame_sync_deframer #(
  parameter logic [15:0] SYNC_WORD   = 16'hEB90,
  parameter int          SYNC_LEN    = 16,
  parameter int          FRAME_BYTES = 32,
  parameter int          MAX_ERR     = 1,
  parameter int          LOCK_CNT    = 2,
  parameter int          LOSS_CNT    = 3
) (
  input  logic       clk_bitsync,
  input  logic       rstn,
  input  logic       bit_en,
  input  logic       bit_in,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_start,
  output logic       frame_end,
  output logic       locked,
  output logic       inverted
);

  localparam int P      = 8 * FRAME_BYTES;
  localparam int PERIOD = P + SYNC_LEN;
  localparam int POS_W  = $clog2(PERIOD);
  localparam int CNT_W  = $clog2((LOCK_CNT > LOSS_CNT ? LOCK_CNT : LOSS_CNT) + 1);

  localparam logic [SYNC_LEN-1:0] SYNC_PAT  = SYNC_WORD[SYNC_LEN-1:0];
  localparam logic [4:0]          ERR_LO    = 5'(MAX_ERR);
  localparam logic [4:0]          ERR_HI    = 5'(SYNC_LEN - MAX_ERR);
  localparam logic [POS_W-1:0]    POS_LAST  = POS_W'(PERIOD - 1);
  localparam logic [POS_W-1:0]    POS_P     = POS_W'(P);
  localparam logic [POS_W-4:0]    LAST_BYTE = (POS_W-3)'(FRAME_BYTES - 1);
  localparam logic [CNT_W-1:0]    LOCK_N    = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0]    LOSS_N    = CNT_W'(LOSS_CNT);

  typedef enum logic [1:0] {S_HUNT, S_VERIFY, S_LOCK} state_t;

  function automatic logic [4:0] f_hamming(input logic [SYNC_LEN-1:0] v);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < SYNC_LEN; i++) cnt = cnt + 5'(v[i]);
    return cnt;
  endfunction

  state_t              r_state, w_state_nxt;
  logic                r_inverted, w_inv_nxt;
  logic [POS_W-1:0]    r_pos, w_pos_nxt;
  logic [CNT_W-1:0]    r_match_cnt, w_match_cnt_nxt;
  logic [CNT_W-1:0]    r_miss_cnt, w_miss_cnt_nxt;
  logic [SYNC_LEN-1:0] r_sr;
  logic [SYNC_LEN-1:0] w_sr_nxt;
  logic [4:0]          w_dist;
  logic                w_match_pos, w_match_neg, w_match;
  logic                w_sync_chk, w_enter_verify;
  logic                w_payload_bit, w_pay_bit;
  logic [CNT_W-1:0]    w_match_inc, w_miss_inc;
  logic [6:0]          r_shift;

  // distance is taken over the shift register value that includes this bit
  assign w_sr_nxt    = {r_sr[SYNC_LEN-2:0], bit_in};
  assign w_dist      = f_hamming(w_sr_nxt ^ SYNC_PAT);
  assign w_match_pos = (w_dist <= ERR_LO);
  assign w_match_neg = (w_dist >= ERR_HI);
  assign w_match     = r_inverted ? w_match_neg : w_match_pos;
  assign w_sync_chk  = bit_en && (r_state != S_HUNT) && (r_pos == POS_LAST);
  assign w_match_inc = r_match_cnt + CNT_W'(1);
  assign w_miss_inc  = r_miss_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt     = r_state;
    w_inv_nxt       = r_inverted;
    w_pos_nxt       = r_pos;
    w_match_cnt_nxt = r_match_cnt;
    w_miss_cnt_nxt  = r_miss_cnt;
    w_enter_verify  = 1'b0;
    case (r_state)
      S_HUNT: begin
        if (bit_en && (w_match_pos || w_match_neg)) begin
          // normal polarity wins if both could ever hold
          w_inv_nxt       = !w_match_pos;
          w_state_nxt     = S_VERIFY;
          w_pos_nxt       = '0;
          w_match_cnt_nxt = CNT_W'(1);
          w_enter_verify  = 1'b1;
        end
      end
      S_VERIFY: begin
        if (bit_en) begin
          w_pos_nxt = w_sync_chk ? '0 : r_pos + POS_W'(1);
          if (w_sync_chk) begin
            if (!w_match) begin
              w_state_nxt = S_HUNT;
            end else if (w_match_inc == LOCK_N) begin
              w_state_nxt    = S_LOCK;
              w_miss_cnt_nxt = '0;
            end else begin
              w_match_cnt_nxt = w_match_inc;
            end
          end
        end
      end
      S_LOCK: begin
        if (bit_en) begin
          w_pos_nxt = w_sync_chk ? '0 : r_pos + POS_W'(1);
          if (w_sync_chk) begin
            if (w_match) begin
              w_miss_cnt_nxt = '0;
            end else if (w_miss_inc == LOSS_N) begin
              w_state_nxt = S_HUNT;
            end else begin
              w_miss_cnt_nxt = w_miss_inc;
            end
          end
        end
      end
      default: w_state_nxt = S_HUNT;
    endcase
  end

  always_ff @(posedge clk_bitsync or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_HUNT;
      r_inverted  <= 1'b0;
      r_pos       <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_sr        <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_inverted  <= w_inv_nxt;
      r_pos       <= w_pos_nxt;
      r_match_cnt <= w_match_cnt_nxt;
      r_miss_cnt  <= w_miss_cnt_nxt;
      if (bit_en) r_sr <= w_sr_nxt;
    end
  end

`ifdef FRAME_DESCRAMBLE_EN
  logic [14:0] r_lfsr;
  logic        w_scr;

  assign w_scr     = r_lfsr[14] ^ r_lfsr[13];
  assign w_pay_bit = bit_in ^ r_inverted ^ w_scr;

  // runs over payload positions in VERIFY too; harmless since every
  // sync check reseeds it before the next payload
  always_ff @(posedge clk_bitsync or negedge rstn) begin
    if (!rstn) begin
      r_lfsr <= 15'h7FFF;
    end else if (w_enter_verify || w_sync_chk) begin
      r_lfsr <= 15'h7FFF;
    end else if (bit_en && (r_state != S_HUNT) && (r_pos < POS_P)) begin
      r_lfsr <= {r_lfsr[13:0], w_scr};
    end
  end
`else
  assign w_pay_bit = bit_in ^ r_inverted;
`endif

  assign w_payload_bit = bit_en && (r_state == S_LOCK) && (r_pos < POS_P);

  // byte assembly: pos[2:0]==7 marks the last bit of a byte
  always_ff @(posedge clk_bitsync or negedge rstn) begin
    if (!rstn) begin
      r_shift     <= '0;
      byte_out    <= '0;
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      if (w_payload_bit) begin
        r_shift <= {r_shift[5:0], w_pay_bit};
        if (r_pos[2:0] == 3'd7) begin
          byte_out    <= {r_shift, w_pay_bit};
          byte_valid  <= 1'b1;
          frame_start <= (r_pos[POS_W-1:3] == '0);
          frame_end   <= (r_pos[POS_W-1:3] == LAST_BYTE);
        end
      end
    end
  end

  assign locked   = (r_state == S_LOCK);
  assign inverted = r_inverted;

endmodule
